// File: rtl/dual_port_sync_ram_if.sv
// Bus bundle for the simple-dual-port RAM: one write port, one read port,
// and the busy flag the requester must wait on after reset.
interface dual_port_sync_ram_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/dual_port_sync_ram.sv
// Simple-dual-port synchronous RAM with byte enables, 1- or 2-cycle read
// latency, selectable read-during-write policy and a post-reset clear sequencer.
module dual_port_sync_ram #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  dual_port_sync_ram_if.slave     bus
);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_reg;
  logic [CNT_WIDTH-1:0]  clr_cnt_reg;
  logic                  busy_reg;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_go;
  logic                  wr_go;
  logic                  rd_go;
  logic                  collide;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_we;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_merged;

  logic                  s1_valid_reg;
  logic [DATA_WIDTH-1:0] s1_data_reg;

  // Requests only count in READY and never on a reset edge.
  assign clr_go  = !rst && (state_reg == CLEAR) && (CLEAR_ON_RESET != 0);
  assign wr_go   = !rst && (state_reg == READY) && bus.wr_en;
  assign rd_go   = !rst && (state_reg == READY) && bus.rd_en;
  assign collide = wr_go && rd_go && (bus.rd_addr == bus.wr_addr) && (RDW_MODE == 1);

  always_comb begin
    mem_addr  = bus.wr_addr;
    mem_wdata = bus.wr_data;
    mem_we    = wr_go ? bus.wr_be : '0;
    if (clr_go) begin
      mem_addr  = clr_cnt_reg[ADDR_WIDTH-1:0];
      mem_wdata = '0;
      mem_we    = '1;
    end
  end

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < BE_WIDTH; lane++) begin
      if (mem_we[lane]) begin
        mem[mem_addr][lane*8 +: 8] <= mem_wdata[lane*8 +: 8];
      end
    end
  end

  assign rd_word = mem[bus.rd_addr];

  // Write-first collisions take new bytes only in the enabled lanes.
  for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_merge
    assign rd_merged[gi*8 +: 8] = (collide && bus.wr_be[gi]) ? bus.wr_data[gi*8 +: 8]
                                                            : rd_word[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
      busy_reg    <= 1'b1;
    end else begin
      case (state_reg)
        CLEAR: begin
          if (CLEAR_ON_RESET == 0) begin
            state_reg <= READY;
            busy_reg  <= 1'b0;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == CNT_WIDTH'(DEPTH - 1)) begin
              state_reg <= READY;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: busy_reg <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= rd_go;
      if (rd_go) begin
        s1_data_reg <= rd_merged;
      end
    end
  end

  assign bus.busy = busy_reg;

  if (READ_LATENCY == 1) begin : g_lat1
    assign bus.rd_valid = s1_valid_reg;
    assign bus.rd_data  = s1_data_reg;
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_reg;
    logic [DATA_WIDTH-1:0] s2_data_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_reg <= 1'b0;
        s2_data_reg  <= '0;
      end else begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_data_reg <= s1_data_reg;
        end
      end
    end

    assign bus.rd_valid = s2_valid_reg;
    assign bus.rd_data  = s2_data_reg;
  end else begin : g_bad_latency
    $error("dual_port_sync_ram: READ_LATENCY must be 1 or 2");
    assign bus.rd_valid = 1'b0;
    assign bus.rd_data  = '0;
  end
endmodule

// File: tb/tb_dual_port_sync_ram.sv
// Drives three RAM configurations with shared stimulus and checks them against
// a word-array reference model of the clear, write, read and collision rules.
module tb_dual_port_sync_ram;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  int assertions = 0;
  int failures = 0;

  // Reference model: word array, remaining clear cycles, expected outputs.
  logic [31:0] mdl_mem [16];
  int          clr_left = 16;
  logic        busy_exp = 1'b1;
  logic        c_busy_exp = 1'b1;
  logic        a_valid_exp = 1'b0;
  logic [31:0] a_data_exp = '0;
  logic        b_valid_exp = 1'b0;
  logic [31:0] b_data_exp = '0;
  logic        b_pend = 1'b0;
  logic [31:0] b_pend_data = '0;

  always #5 clk = ~clk;

  dual_port_sync_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) if_a ();
  dual_port_sync_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) if_b ();
  dual_port_sync_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) if_c ();

  assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;   assign if_c.wr_en = wr_en;
  assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr; assign if_c.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data; assign if_c.wr_data = wr_data;
  assign if_a.wr_be = wr_be;   assign if_b.wr_be = wr_be;   assign if_c.wr_be = wr_be;
  assign if_a.rd_en = rd_en;   assign if_b.rd_en = rd_en;   assign if_c.rd_en = rd_en;
  assign if_a.rd_addr = rd_addr; assign if_b.rd_addr = rd_addr; assign if_c.rd_addr = rd_addr;

  // A: latency 1, read-first.  B: latency 2, write-first.  C: no clear.
  dual_port_sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .RDW_MODE(0),
                       .CLEAR_ON_RESET(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  dual_port_sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2), .RDW_MODE(1),
                       .CLEAR_ON_RESET(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  dual_port_sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .RDW_MODE(0),
                       .CLEAR_ON_RESET(0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // One clock: drive inputs, advance the model at the edge, sample 1 time unit later.
  task automatic step(input logic r, input logic we, input logic [3:0] wa,
                      input logic [31:0] wd, input logic [3:0] wbe,
                      input logic re, input logic [3:0] ra);
    logic [31:0] old_word;
    logic [31:0] new_word;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe; rd_en = re; rd_addr = ra;
    @(posedge clk);
    if (r) begin
      clr_left = 16; c_busy_exp = 1'b1;
      a_valid_exp = 1'b0; a_data_exp = '0;
      b_valid_exp = 1'b0; b_data_exp = '0; b_pend = 1'b0; b_pend_data = '0;
    end else begin
      c_busy_exp = 1'b0;
      b_valid_exp = b_pend;
      if (b_pend) b_data_exp = b_pend_data;
      b_pend = 1'b0;
      a_valid_exp = 1'b0;
      if (clr_left > 0) begin
        mdl_mem[16 - clr_left] = '0;
        clr_left--;
      end else begin
        old_word = mdl_mem[ra];
        new_word = mdl_mem[wa];
        for (int l = 0; l < 4; l++) if (wbe[l]) new_word[l*8 +: 8] = wd[l*8 +: 8];
        if (re) begin
          a_valid_exp = 1'b1; a_data_exp = old_word;
          b_pend = 1'b1; b_pend_data = (we && wa == ra) ? new_word : old_word;
          $display("rd addr=%0d old=%h", ra, old_word);
        end
        if (we) begin
          mdl_mem[wa] = new_word;
          $display("wr addr=%0d data=%h be=%b -> %h", wa, wd, wbe, new_word);
        end
      end
    end
    busy_exp = r || (clr_left > 0);
    #1;
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    idle(1'b1); idle(1'b1);
    for (int i = 0; i < 16; i++) idle(1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), 32'hFFFF_FFFF, 4'hF, 1'b0, 4'd0);
    idle(1'b1); idle(1'b1);
    assertions += 5;
    if (if_a.busy !== 1'b1) begin failures++; $display("FAIL reset_busy_a: got %b expected 1", if_a.busy); end
    if (if_c.busy !== 1'b1) begin failures++; $display("FAIL reset_busy_c: got %b expected 1", if_c.busy); end
    if (if_a.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_a: got %b expected 0", if_a.rd_valid); end
    if (if_a.rd_data !== 32'd0) begin failures++; $display("FAIL reset_data_a: got %h expected 0", if_a.rd_data); end
    if (if_b.rd_data !== 32'd0) begin failures++; $display("FAIL reset_data_b: got %h expected 0", if_b.rd_data); end
    for (int i = 0; i < 16; i++) begin
      idle(1'b0);
      assertions += 3;
      if (if_a.busy !== (i < 15)) begin failures++; $display("FAIL clear_busy_a cycle %0d: got %b expected %b", i, if_a.busy, (i < 15)); end
      if (if_b.busy !== busy_exp) begin failures++; $display("FAIL clear_busy_b cycle %0d: got %b expected %b", i, if_b.busy, busy_exp); end
      if (if_c.busy !== 1'b0) begin failures++; $display("FAIL noclear_busy_c cycle %0d: got %b expected 0", i, if_c.busy); end
    end
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, i < 16, 4'(i));
      assertions += 4;
      if (if_a.rd_valid !== (i < 16)) begin failures++; $display("FAIL clear_rd_valid_a %0d: got %b expected %b", i, if_a.rd_valid, (i < 16)); end
      if (if_a.rd_data !== 32'd0) begin failures++; $display("FAIL clear_rd_data_a %0d: got %h expected 0", i, if_a.rd_data); end
      if (if_b.rd_valid !== (i >= 1)) begin failures++; $display("FAIL clear_rd_valid_b %0d: got %b expected %b", i, if_b.rd_valid, (i >= 1)); end
      if (if_b.rd_data !== 32'd0) begin failures++; $display("FAIL clear_rd_data_b %0d: got %h expected 0", i, if_b.rd_data); end
    end
  endtask

  task automatic test_write_read_sweep();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), $urandom, 4'hF, 1'b0, 4'd0);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, i < 16, 4'(i));
      assertions += 4;
      if (if_a.rd_valid !== (i < 16)) begin failures++; $display("FAIL sweep_valid_a %0d: got %b expected %b", i, if_a.rd_valid, (i < 16)); end
      if (if_a.rd_data !== a_data_exp) begin failures++; $display("FAIL sweep_data_a %0d: got %h expected %h", i, if_a.rd_data, a_data_exp); end
      if (if_b.rd_valid !== (i >= 1 && i < 17)) begin failures++; $display("FAIL sweep_valid_b %0d: got %b expected %b", i, if_b.rd_valid, (i >= 1 && i < 17)); end
      if (if_b.rd_data !== b_data_exp) begin failures++; $display("FAIL sweep_data_b %0d: got %h expected %h", i, if_b.rd_data, b_data_exp); end
    end
  endtask

  task automatic test_byte_enables();
    step(1'b0, 1'b1, 4'd5, 32'hAABB_CCDD, 4'b1111, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd5, 32'h1122_3344, 4'b0101, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5);
    assertions++;
    if (if_a.rd_data !== 32'hAA22_CC44) begin failures++; $display("FAIL be_merge_a: got %h expected aa22cc44", if_a.rd_data); end
    step(1'b0, 1'b1, 4'd5, 32'hFFFF_FFFF, 4'b0000, 1'b0, 4'd0);
    assertions++;
    if (if_b.rd_data !== 32'hAA22_CC44) begin failures++; $display("FAIL be_merge_b: got %h expected aa22cc44", if_b.rd_data); end
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5);
    idle(1'b0);
    assertions += 2;
    if (if_a.rd_data !== 32'hAA22_CC44) begin failures++; $display("FAIL be_zero_a: got %h expected aa22cc44", if_a.rd_data); end
    if (if_b.rd_data !== 32'hAA22_CC44) begin failures++; $display("FAIL be_zero_b: got %h expected aa22cc44", if_b.rd_data); end
  endtask

  task automatic test_read_during_write();
    step(1'b0, 1'b1, 4'd7, 32'h0000_5555, 4'hF, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd7, 32'h0000_A5A5, 4'b0001, 1'b1, 4'd7);
    assertions++;
    if (if_a.rd_data !== 32'h0000_5555) begin failures++; $display("FAIL rdw_read_first: got %h expected 00005555", if_a.rd_data); end
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd7);
    assertions += 2;
    if (if_b.rd_data !== 32'h0000_55A5) begin failures++; $display("FAIL rdw_write_first: got %h expected 000055a5", if_b.rd_data); end
    if (if_a.rd_data !== 32'h0000_55A5) begin failures++; $display("FAIL rdw_after_a: got %h expected 000055a5", if_a.rd_data); end
    idle(1'b0);
    assertions++;
    if (if_b.rd_data !== 32'h0000_55A5) begin failures++; $display("FAIL rdw_after_b: got %h expected 000055a5", if_b.rd_data); end
  endtask

  task automatic test_reset_mid_clear();
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2);
    idle(1'b1);
    assertions += 2;
    if (if_b.rd_valid !== 1'b0) begin failures++; $display("FAIL midread_flush_b: got %b expected 0", if_b.rd_valid); end
    if (if_a.rd_data !== 32'd0) begin failures++; $display("FAIL midread_data_a: got %h expected 0", if_a.rd_data); end
    idle(1'b0);
    assertions++;
    if (if_b.rd_valid !== 1'b0) begin failures++; $display("FAIL midread_late_b: got %b expected 0", if_b.rd_valid); end
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'd3);
      assertions += 3;
      if (if_a.busy !== (i < 15)) begin failures++; $display("FAIL midclear_busy %0d: got %b expected %b", i, if_a.busy, (i < 15)); end
      if (if_a.rd_valid !== 1'b0) begin failures++; $display("FAIL busy_read_a %0d: got %b expected 0", i, if_a.rd_valid); end
      if (if_b.rd_valid !== 1'b0) begin failures++; $display("FAIL busy_read_b %0d: got %b expected 0", i, if_b.rd_valid); end
    end
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3);
    assertions += 2;
    if (if_a.rd_valid !== 1'b1) begin failures++; $display("FAIL ignored_wr_valid: got %b expected 1", if_a.rd_valid); end
    if (if_a.rd_data !== 32'd0) begin failures++; $display("FAIL ignored_wr_data: got %h expected 0", if_a.rd_data); end
    idle(1'b0);
  endtask

  task automatic test_latency2();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'(i), 32'h10 + 32'(i), 4'hF, 1'b0, 4'd0);
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, j < 4, 4'(j));
      assertions++;
      if (if_b.rd_valid !== (j >= 1)) begin failures++; $display("FAIL lat2_valid %0d: got %b expected %b", j, if_b.rd_valid, (j >= 1)); end
      if (j >= 1) begin
        assertions++;
        if (if_b.rd_data !== 32'h10 + 32'(j - 1)) begin failures++; $display("FAIL lat2_data %0d: got %h expected %h", j, if_b.rd_data, 32'h10 + 32'(j - 1)); end
      end
    end
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'($urandom), 4'($urandom_range(0, 15)), $urandom, 4'($urandom),
           1'($urandom), 4'($urandom_range(0, 15)));
      assertions += 5;
      if (if_a.rd_valid !== a_valid_exp) begin failures++; $display("FAIL rand_valid_a %0d: got %b expected %b", i, if_a.rd_valid, a_valid_exp); end
      if (if_a.rd_data !== a_data_exp) begin failures++; $display("FAIL rand_data_a %0d: got %h expected %h", i, if_a.rd_data, a_data_exp); end
      if (if_b.rd_valid !== b_valid_exp) begin failures++; $display("FAIL rand_valid_b %0d: got %b expected %b", i, if_b.rd_valid, b_valid_exp); end
      if (if_b.rd_data !== b_data_exp) begin failures++; $display("FAIL rand_data_b %0d: got %h expected %h", i, if_b.rd_data, b_data_exp); end
      if (if_a.busy !== busy_exp) begin failures++; $display("FAIL rand_busy %0d: got %b expected %b", i, if_a.busy, busy_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read_sweep();
    test_byte_enables();
    test_read_during_write();
    test_reset_mid_clear();
    test_latency2();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/dual_port_sync_ram.md
# dual_port_sync_ram

Parametrised simple-dual-port synchronous RAM that succeeds the single-port chip-select RAM in the memory subsystem. It has one write port and one read port on a single clock. On top of the single-port part it adds:
- per-byte write enables;
- selectable read latency (1 or 2 cycles) with a valid strobe;
- a defined read-during-write policy;
- a hardware clear sequencer that zeroes the whole array after reset.

It replaces the tri-state data bus with separate read and write data paths. It serves as a scratchpad and buffer store for the datapath.

## Interface
- ADDR_WIDTH, 12, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, word width; must be a multiple of 8. BE_WIDTH = DATA_WIDTH/8.
- READ_LATENCY, 1, legal values 1 or 2; any other value is a configuration error.
- RDW_MODE, 0, read-during-write policy on a same-address collision: 0 = read-first (old data), 1 = write-first (new data).
- CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = skip clearing (contents undefined).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr_en  input  1  write request, sampled at the rising edge.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_be  input  BE_WIDTH  byte enables; bit i gates bits [8i+7:8i].
- rd_en  input  1  read request, sampled at the rising edge.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  read data; held between reads.
- rd_valid  output  1  one-cycle strobe marking rd_data valid.
- busy  output  1  high during reset and while clearing; requests are ignored while high.

## Operation
- FSM states are CLEAR and READY.
- Reset behaviour: at any edge with rst=1, the block enters CLEAR, sets clear counter = 0, and flushes the read pipeline.
- CLEAR state, while rst=1: the counter holds at 0.
- CLEAR state, each edge with rst=0: writes 0 to all bytes of word[counter], then increments the counter.
- Leaving CLEAR: after the write to address DEPTH-1, the FSM goes to READY. The counter is ADDR_WIDTH+1 bits so the terminal count is unambiguous.
- CLEAR_ON_RESET=0: the first edge with rst=0 moves the FSM directly to READY.
- Requests in CLEAR: wr_en and rd_en are dropped with no memory effect and no rd_valid. The requester must hold requests off until busy=0.
- Write in READY: wr_en=1 updates only the lanes whose wr_be bit is 1. wr_be=0 with wr_en=1 is a no-op.
- Read in READY: rd_en=1 is accepted. Reads are fully pipelined: one accepted read per cycle, returned in order.
- Collision (rd_en, wr_en, rd_addr==wr_addr at the same edge):
  - RDW_MODE 0 returns the pre-write word.
  - RDW_MODE 1 returns a per-lane merge: wr_data bytes in enabled lanes, old bytes in disabled lanes.
- Addresses wrap naturally modulo DEPTH; there is no out-of-range case.
- Reset mid-clear: the counter restarts at 0 and a full DEPTH-cycle clear follows the next rst release.
- Reset mid-read: in-flight reads are discarded and no rd_valid is produced for them.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=1.
- busy is a registered output:
  - it is 1 from the first edge with rst=1;
  - it stays 1 through the edge that clears address DEPTH-1;
  - it falls after edge k+DEPTH-1, where k is the first edge with rst=0;
  - the first accepted request is sampled at edge k+DEPTH;
  - with CLEAR_ON_RESET=0, busy falls after edge k.
- READ_LATENCY=1: a read accepted at edge N gives rd_data/rd_valid valid immediately after edge N.
- READ_LATENCY=2: a read accepted at edge N gives rd_data/rd_valid valid after edge N+1.
- rd_valid is high for exactly one cycle per accepted read. Back-to-back reads produce a continuous rd_valid.
- Write visibility: a write at edge N is visible to any read accepted at edge N+1 or later. Same-edge visibility follows RDW_MODE.
- rd_data keeps its last value when rd_valid=0.

## Test plan
- Reset clear (ADDR_WIDTH=4, DATA_WIDTH=8): pre-fill with 0xFF, pulse rst for 2 cycles -> busy high for exactly 16 cycles after release; reads of addresses 0..15 all return 0x00 with rd_valid.
- Write/read sweep: write $random bytes to addresses 0..15 with wr_be=1, then read 0..15 back-to-back -> each value returned one cycle after its request; rd_valid high for 16 consecutive cycles.
- Byte enables (DATA_WIDTH=32):
  - write 0xAABBCCDD with be=4'b1111;
  - then write 0x11223344 with be=4'b0101 to the same address;
  - read -> 0xAA22CC44;
  - write with be=0 -> word unchanged.
- Read-during-write (DATA_WIDTH=16): the word at address 7 holds 0x5555; issue a simultaneous read and a write of 0xA5A5 with be=2'b01 to address 7:
  - RDW_MODE 0 -> returns 0x5555;
  - RDW_MODE 1 -> returns 0x55A5;
  - in both modes, a subsequent read returns 0x55A5.
- Reset mid-clear plus ignored requests:
  - assert rst on the 5th clear cycle;
  - after release, busy lasts a full 16 cycles;
  - a write of 0xFF to address 3 issued while busy has no effect, and a later read of address 3 returns 0x00;
  - a read issued while busy produces no rd_valid.
- READ_LATENCY=2: 4 back-to-back reads of addresses 0..3 holding 0x10..0x13 -> rd_valid high on the 4 cycles following the edge after the first request; data 0x10..0x13 in order.
